// File: rtl/head_table_wr_arb.sv
// Head table write-port controller: round-robin arbitration among N_REQ writers
// plus a full-table clear sweep that preempts all requesters.
module head_table_wr_arb #(
  parameter int unsigned N_REQ     = 3,
  parameter int unsigned A_WIDTH   = 4,
  parameter int unsigned PTR_WIDTH = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_n_i,
  input  logic [N_REQ-1:0]             req_valid_i,
  output logic [N_REQ-1:0]             req_ready_o,
  input  logic [N_REQ*A_WIDTH-1:0]     req_addr_i,
  input  logic [N_REQ*PTR_WIDTH-1:0]   req_ptr_i,
  input  logic [N_REQ-1:0]             req_ptr_val_i,
  input  logic                         clear_run_i,
  output logic                         clear_busy_o,
  output logic                         clear_done_o,
  output logic [A_WIDTH-1:0]           wr_addr_o,
  output logic [PTR_WIDTH-1:0]         wr_data_ptr_o,
  output logic                         wr_data_ptr_val_o,
  output logic                         wr_en_o
);

  localparam int unsigned GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic {ARB, CLEAR} state_e;

  state_e               state_q, state_d;
  logic [GW-1:0]        last_grant_q, last_grant_d;
  logic [GW-1:0]        grant, idx;
  logic                 grant_vld;
  logic                 accept;
  logic [A_WIDTH-1:0]   sel_addr, addr_inc;
  logic [PTR_WIDTH-1:0] sel_ptr;
  logic                 sel_ptr_val;

  logic [A_WIDTH-1:0]   wr_addr_d;
  logic [PTR_WIDTH-1:0] wr_data_ptr_d;
  logic                 wr_data_ptr_val_d, wr_en_d, clear_busy_d, clear_done_d;

  // Round-robin search starting just above the last granted index.
  always_comb begin
    grant     = '0;
    grant_vld = 1'b0;
    idx       = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      idx = GW'((32'(last_grant_q) + 32'd1 + i) % N_REQ);
      if (!grant_vld && req_valid_i[idx]) begin
        grant     = idx;
        grant_vld = 1'b1;
      end
    end
  end

  always_comb begin
    sel_addr    = '0;
    sel_ptr     = '0;
    sel_ptr_val = 1'b0;
    for (int unsigned j = 0; j < N_REQ; j++) begin
      if (grant == GW'(j)) begin
        sel_addr    = req_addr_i[j*A_WIDTH +: A_WIDTH];
        sel_ptr     = req_ptr_i[j*PTR_WIDTH +: PTR_WIDTH];
        sel_ptr_val = req_ptr_val_i[j];
      end
    end
  end

  assign accept      = rst_n_i && (state_q == ARB) && !clear_run_i && grant_vld;
  assign req_ready_o = accept ? (N_REQ'(1) << grant) : '0;
  assign addr_inc    = wr_addr_o + A_WIDTH'(1);

  always_comb begin
    state_d           = state_q;
    last_grant_d      = last_grant_q;
    wr_addr_d         = wr_addr_o;
    wr_data_ptr_d     = wr_data_ptr_o;
    wr_data_ptr_val_d = wr_data_ptr_val_o;
    wr_en_d           = 1'b0;
    clear_busy_d      = clear_busy_o;
    clear_done_d      = 1'b0;
    // A clear pulse starts or restarts the sweep from either state.
    if (clear_run_i) begin
      state_d           = CLEAR;
      wr_addr_d         = '0;
      wr_data_ptr_d     = '0;
      wr_data_ptr_val_d = 1'b0;
      wr_en_d           = 1'b1;
      clear_busy_d      = 1'b1;
    end else begin
      case (state_q)
        ARB: begin
          if (accept) begin
            wr_addr_d         = sel_addr;
            wr_data_ptr_d     = sel_ptr;
            wr_data_ptr_val_d = sel_ptr_val;
            wr_en_d           = 1'b1;
            last_grant_d      = grant;
          end
        end
        CLEAR: begin
          if (wr_addr_o == '1) begin
            state_d      = ARB;
            clear_busy_d = 1'b0;
          end else begin
            wr_addr_d         = addr_inc;
            wr_data_ptr_d     = '0;
            wr_data_ptr_val_d = 1'b0;
            wr_en_d           = 1'b1;
            clear_busy_d      = 1'b1;
            clear_done_d      = (addr_inc == '1);
          end
        end
        default: state_d = ARB;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q           <= ARB;
      last_grant_q      <= GW'(N_REQ - 1);
      wr_addr_o         <= '0;
      wr_data_ptr_o     <= '0;
      wr_data_ptr_val_o <= 1'b0;
      wr_en_o           <= 1'b0;
      clear_busy_o      <= 1'b0;
      clear_done_o      <= 1'b0;
    end else begin
      state_q           <= state_d;
      last_grant_q      <= last_grant_d;
      wr_addr_o         <= wr_addr_d;
      wr_data_ptr_o     <= wr_data_ptr_d;
      wr_data_ptr_val_o <= wr_data_ptr_val_d;
      wr_en_o           <= wr_en_d;
      clear_busy_o      <= clear_busy_d;
      clear_done_o      <= clear_done_d;
    end
  end

endmodule

// File: tb/tb_head_table_wr_arb.sv
// Directed bench for head_table_wr_arb: table-driven arbitration vectors plus
// hand-written clear-sweep, restart and mid-sweep reset sequences.
module tb_head_table_wr_arb;

  localparam int unsigned N = 3;
  localparam int unsigned AW = 4;
  localparam int unsigned PW = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*AW-1:0] req_addr;
  logic [N*PW-1:0] req_ptr;
  logic [N-1:0]    req_ptr_val;
  logic            clear_run;
  logic            clear_busy, clear_done;
  logic [AW-1:0]   wr_addr;
  logic [PW-1:0]   wr_ptr;
  logic            wr_ptr_val, wr_en;

  int n_tests = 0;
  int n_fail  = 0;

  head_table_wr_arb #(.N_REQ(N), .A_WIDTH(AW), .PTR_WIDTH(PW)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_addr_i(req_addr), .req_ptr_i(req_ptr), .req_ptr_val_i(req_ptr_val),
    .clear_run_i(clear_run), .clear_busy_o(clear_busy), .clear_done_o(clear_done),
    .wr_addr_o(wr_addr), .wr_data_ptr_o(wr_ptr), .wr_data_ptr_val_o(wr_ptr_val),
    .wr_en_o(wr_en)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] valid;
    logic [2:0] exp_ready;
    logic       exp_en;
    logic [3:0] exp_addr;
    logic [3:0] exp_ptr;
    logic       exp_pval;
  } vec_t;

  vec_t vecs[12];
  logic [3:0] req_a[3];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    // requester 0: addr 5 ptr 3 val 1; requester 1: addr A ptr 6 val 0; requester 2: addr C ptr 9 val 1
    req_addr    = 12'hCA5;
    req_ptr     = 12'h963;
    req_ptr_val = 3'b101;
    req_a[0] = 4'h5; req_a[1] = 4'hA; req_a[2] = 4'hC;

    vecs[0]  = '{3'b000, 3'b000, 1'b0, 4'h0, 4'h0, 1'b0};
    vecs[1]  = '{3'b001, 3'b001, 1'b1, 4'h5, 4'h3, 1'b1};
    vecs[2]  = '{3'b000, 3'b000, 1'b0, 4'h5, 4'h3, 1'b1};
    vecs[3]  = '{3'b111, 3'b010, 1'b1, 4'hA, 4'h6, 1'b0};
    vecs[4]  = '{3'b111, 3'b100, 1'b1, 4'hC, 4'h9, 1'b1};
    vecs[5]  = '{3'b111, 3'b001, 1'b1, 4'h5, 4'h3, 1'b1};
    vecs[6]  = '{3'b101, 3'b100, 1'b1, 4'hC, 4'h9, 1'b1};
    vecs[7]  = '{3'b011, 3'b001, 1'b1, 4'h5, 4'h3, 1'b1};
    vecs[8]  = '{3'b110, 3'b010, 1'b1, 4'hA, 4'h6, 1'b0};
    vecs[9]  = '{3'b100, 3'b100, 1'b1, 4'hC, 4'h9, 1'b1};
    vecs[10] = '{3'b001, 3'b001, 1'b1, 4'h5, 4'h3, 1'b1};
    vecs[11] = '{3'b000, 3'b000, 1'b0, 4'h5, 4'h3, 1'b1};

    // Reset with requests pending: ready must stay low, outputs cleared.
    rst_n = 1'b0; req_valid = 3'b111; clear_run = 1'b0;
    tick(); tick();
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_en", 32'(wr_en), 0);
    chk("rst_addr", 32'(wr_addr), 0);
    chk("rst_ptr", 32'(wr_ptr), 0);
    chk("rst_pval", 32'(wr_ptr_val), 0);
    chk("rst_busy", 32'(clear_busy), 0);
    chk("rst_done", 32'(clear_done), 0);
    req_valid = '0;
    rst_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      tick();
      chk("idle_en", 32'(wr_en), 0);
    end

    for (int i = 0; i < 12; i++) begin
      req_valid = vecs[i].valid;
      #1;
      chk($sformatf("v%0d_ready", i), 32'(req_ready), 32'(vecs[i].exp_ready));
      tick();
      chk($sformatf("v%0d_en", i), 32'(wr_en), 32'(vecs[i].exp_en));
      chk($sformatf("v%0d_addr", i), 32'(wr_addr), 32'(vecs[i].exp_addr));
      chk($sformatf("v%0d_ptr", i), 32'(wr_ptr), 32'(vecs[i].exp_ptr));
      chk($sformatf("v%0d_pval", i), 32'(wr_ptr_val), 32'(vecs[i].exp_pval));
    end

    // Clear sweep with requester 1 held valid; its prior accepted write survives.
    req_valid = 3'b010;
    #1;
    chk("b_pre_ready", 32'(req_ready), 32'(3'b010));
    tick();
    clear_run = 1'b1;
    #1;
    chk("b_clr_ready", 32'(req_ready), 0);
    chk("b_inflight_en", 32'(wr_en), 1);
    chk("b_inflight_addr", 32'(wr_addr), 32'h0A);
    tick();
    clear_run = 1'b0;
    #1;
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("b_en%0d", k), 32'(wr_en), 1);
      chk($sformatf("b_addr%0d", k), 32'(wr_addr), 32'(k));
      chk($sformatf("b_ptr%0d", k), 32'({wr_ptr_val, wr_ptr}), 0);
      chk($sformatf("b_busy%0d", k), 32'(clear_busy), 1);
      chk($sformatf("b_done%0d", k), 32'(clear_done), (k == 15) ? 1 : 0);
      chk($sformatf("b_ready%0d", k), 32'(req_ready), 0);
      tick();
    end
    chk("b_after_ready", 32'(req_ready), 32'(3'b010));
    chk("b_after_busy", 32'(clear_busy), 0);
    chk("b_after_done", 32'(clear_done), 0);
    chk("b_after_en", 32'(wr_en), 0);
    tick();
    chk("b_post_en", 32'(wr_en), 1);
    chk("b_post_addr", 32'(wr_addr), 32'h0A);
    req_valid = '0;

    // Restart at sweep address 7.
    clear_run = 1'b1;
    tick();
    clear_run = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("c1_addr%0d", k), 32'(wr_addr), 32'(k));
      chk($sformatf("c1_done%0d", k), 32'(clear_done), 0);
      if (k == 7) clear_run = 1'b1;
      tick();
      clear_run = 1'b0;
    end
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("c2_addr%0d", k), 32'(wr_addr), 32'(k));
      chk($sformatf("c2_en%0d", k), 32'(wr_en), 1);
      chk($sformatf("c2_done%0d", k), 32'(clear_done), (k == 15) ? 1 : 0);
      tick();
    end
    chk("c_end_busy", 32'(clear_busy), 0);
    chk("c_end_done", 32'(clear_done), 0);

    // Reset at sweep address 9, then requester 0 must win first.
    clear_run = 1'b1;
    tick();
    clear_run = 1'b0;
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("d_addr%0d", k), 32'(wr_addr), 32'(k));
      if (k == 9) rst_n = 1'b0;
      tick();
    end
    chk("d_rst_en", 32'(wr_en), 0);
    chk("d_rst_busy", 32'(clear_busy), 0);
    chk("d_rst_done", 32'(clear_done), 0);
    rst_n = 1'b1;
    req_valid = 3'b111;
    for (int j = 0; j < 6; j++) begin
      #1;
      chk($sformatf("rot%0d_ready", j), 32'(req_ready), 32'(3'b001 << (j % 3)));
      tick();
      chk($sformatf("rot%0d_en", j), 32'(wr_en), 1);
      chk($sformatf("rot%0d_addr", j), 32'(wr_addr), 32'(req_a[j % 3]));
    end
    req_valid = '0;
    tick();
    chk("final_en", 32'(wr_en), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
